// File: rtl/jb_rf_protect_ctrl.sv
// ---------------------------------------------------------------------------------------------
// jb_rf_protect_ctrl
//
// Multi-channel RF power protection engine for the PA lineup. Each channel receives one power
// sample per pwr_valid strobe. The engine provides two kinds of protection:
//   - Overdrive protection (ODP): a saturating sum is taken over a window of avg_per samples.
//     The channel trips if the completed window sum exceeds od_thresh.
//   - Slew-rate protection (SRP): the channel trips after slew_dur_limit consecutive samples
//     whose step |sample - prev| exceeds slew_limit.
// A channel's trips are latched by a per-channel ARMED/TRIPPED state machine. They are cleared
// by trip_clr. With AUTO_REARM set, an ODP trip also clears after a clean window.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   pwr_valid         one new sample on every channel this cycle
//   pwr_data          channel i sample at [i*SAMPLE_W +: SAMPLE_W]
//   od_thresh         ODP threshold on the window sum
//   avg_per           samples per window (0 behaves as 1)
//   slew_limit        largest allowed step between consecutive samples
//   slew_dur_limit    consecutive violating samples needed to trip (0 behaves as 1)
//   disable_odp/srp   per-channel protection disables; these force the trip low
//   trip_clr          per-channel pulse clearing both latched trips
//   tssi              last completed window sum per channel
//   tssi_valid        one-cycle pulse per completed window
//   odp_trip/srp_trip latched trips
//   pa_sleep          odp_trip | srp_trip
// ---------------------------------------------------------------------------------------------
module jb_rf_protect_ctrl #(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned SAMPLE_W   = 16,
   parameter int unsigned ACC_W      = 32,
   parameter int unsigned PER_W      = 21,
   parameter int unsigned DUR_W      = 16,
   parameter bit          AUTO_REARM = 1'b0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         pwr_valid,
   input  logic [NUM_CH*SAMPLE_W-1:0]   pwr_data,
   input  logic [ACC_W-1:0]             od_thresh,
   input  logic [PER_W-1:0]             avg_per,
   input  logic [SAMPLE_W:0]            slew_limit,
   input  logic [DUR_W-1:0]             slew_dur_limit,
   input  logic [NUM_CH-1:0]            disable_odp,
   input  logic [NUM_CH-1:0]            disable_srp,
   input  logic [NUM_CH-1:0]            trip_clr,
   output logic [NUM_CH*ACC_W-1:0]      tssi,
   output logic                         tssi_valid,
   output logic [NUM_CH-1:0]            odp_trip,
   output logic [NUM_CH-1:0]            srp_trip,
   output logic [NUM_CH-1:0]            pa_sleep
);

   // The sum is wide enough for either operand, so a carry out is never lost before it saturates.
   localparam int unsigned      SUM_W    = ((ACC_W > SAMPLE_W) ? ACC_W : SAMPLE_W) + 1;
   localparam logic [ACC_W-1:0] ACC_ONES = '1;
   localparam logic [DUR_W:0]   DUR_ONE  = 1;

   typedef enum logic [0:0] {StArmed, StTripped} trip_state_e;

   // ------------------------------------------------------------------------------------------
   // Shared window counter
   // ------------------------------------------------------------------------------------------
   logic [PER_W-1:0] r_scnt;
   logic [PER_W-1:0] w_per_m1;
   logic             w_win_end;
   logic             r_tssi_valid;

   assign w_per_m1 = (avg_per == '0) ? '0 : avg_per - 1'b1;
   // The >= compare ends the window on the next sample when avg_per is lowered mid-window.
   assign w_win_end = pwr_valid && (r_scnt >= w_per_m1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scnt       <= '0;
         r_tssi_valid <= 1'b0;
      end else begin
         r_tssi_valid <= w_win_end;
         if (pwr_valid) begin
            r_scnt <= w_win_end ? '0 : r_scnt + 1'b1;
         end
      end
   end

   assign tssi_valid = r_tssi_valid;

   // ------------------------------------------------------------------------------------------
   // Per-channel datapath and trip state machine
   // ------------------------------------------------------------------------------------------
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [SAMPLE_W-1:0] w_sample;
      logic [SUM_W-1:0]    w_sum_raw;
      logic [ACC_W-1:0]    w_sum;
      logic [SAMPLE_W:0]   w_diff;
      logic [DUR_W:0]      w_cnt_inc;
      logic [DUR_W:0]      w_dur_min;
      logic                w_viol;
      logic                w_odp_set;
      logic                w_srp_set;
      logic                w_rearm;

      logic [ACC_W-1:0]    r_acc;
      logic [ACC_W-1:0]    r_tssi;
      logic [SAMPLE_W-1:0] r_prev;
      logic                r_prev_ok;
      logic [DUR_W-1:0]    r_viol_cnt;
      logic [DUR_W-1:0]    w_viol_cnt_nxt;
      logic                r_odp;
      logic                r_srp;
      logic                w_odp_nxt;
      logic                w_srp_nxt;
      trip_state_e         r_state;
      trip_state_e         w_state_nxt;

      assign w_sample  = pwr_data[i*SAMPLE_W +: SAMPLE_W];
      assign w_sum_raw = SUM_W'(r_acc) + SUM_W'(w_sample);
      assign w_sum     = (w_sum_raw > SUM_W'(ACC_ONES)) ? ACC_ONES : w_sum_raw[ACC_W-1:0];

      assign w_diff = (w_sample >= r_prev) ? ({1'b0, w_sample} - {1'b0, r_prev})
                                           : ({1'b0, r_prev} - {1'b0, w_sample});

      // The first sample after reset has no predecessor, so it is never a violation.
      assign w_viol    = pwr_valid && r_prev_ok && !disable_srp[i] && (w_diff > slew_limit);
      assign w_cnt_inc = {1'b0, r_viol_cnt} + 1'b1;
      assign w_dur_min = (slew_dur_limit == '0) ? DUR_ONE : {1'b0, slew_dur_limit};
      assign w_srp_set = w_viol && (w_cnt_inc >= w_dur_min);

      assign w_odp_set = w_win_end && (w_sum > od_thresh) && !disable_odp[i];
      // Auto-rearm only clears ODP, and never while the channel also holds a slew trip.
      assign w_rearm   = AUTO_REARM && w_win_end && (w_sum <= od_thresh) && !w_viol && !r_srp;

      always_comb begin
         w_viol_cnt_nxt = r_viol_cnt;
         if (disable_srp[i]) begin
            w_viol_cnt_nxt = '0;
         end else if (pwr_valid) begin
            if (!w_viol) begin
               w_viol_cnt_nxt = '0;
            end else if (!(&r_viol_cnt)) begin
               w_viol_cnt_nxt = r_viol_cnt + 1'b1;
            end
         end
      end

      always_comb begin
         w_state_nxt = r_state;
         w_odp_nxt   = r_odp;
         w_srp_nxt   = r_srp;
         unique case (r_state)
            StArmed: begin
               w_odp_nxt = r_odp;
            end
            StTripped: begin
               if (trip_clr[i]) begin
                  w_odp_nxt = 1'b0;
                  w_srp_nxt = 1'b0;
               end else if (w_rearm) begin
                  w_odp_nxt = 1'b0;
               end
            end
            default: begin
               w_odp_nxt = 1'b0;
               w_srp_nxt = 1'b0;
            end
         endcase
         // A set in the same cycle as a clear wins. Disables override everything.
         if (w_odp_set) w_odp_nxt = 1'b1;
         if (w_srp_set) w_srp_nxt = 1'b1;
         if (disable_odp[i]) w_odp_nxt = 1'b0;
         if (disable_srp[i]) w_srp_nxt = 1'b0;
         w_state_nxt = (w_odp_nxt || w_srp_nxt) ? StTripped : StArmed;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_acc      <= '0;
            r_tssi     <= '0;
            r_prev     <= '0;
            r_prev_ok  <= 1'b0;
            r_viol_cnt <= '0;
            r_odp      <= 1'b0;
            r_srp      <= 1'b0;
            r_state    <= StArmed;
         end else begin
            r_viol_cnt <= w_viol_cnt_nxt;
            r_odp      <= w_odp_nxt;
            r_srp      <= w_srp_nxt;
            r_state    <= w_state_nxt;
            if (pwr_valid) begin
               r_prev    <= w_sample;
               r_prev_ok <= 1'b1;
               if (w_win_end) begin
                  r_tssi <= w_sum;
                  r_acc  <= '0;
               end else begin
                  r_acc  <= w_sum;
               end
            end
         end
      end

      assign tssi[i*ACC_W +: ACC_W] = r_tssi;
      assign odp_trip[i]            = r_odp;
      assign srp_trip[i]            = r_srp;
      assign pa_sleep[i]            = r_odp | r_srp;
   end

endmodule
